// File: rtl/iter_mul.sv
// ---------------------------------------------------------------------------
// iter_mul : iterative radix-2^DIGIT shift-add multiplier with valid/ready
//            handshakes on both sides and a signed/unsigned mode.
//
// The operand magnitudes are captured on acceptance. The multiplier magnitude
// is consumed DIGIT bits per cycle, LSB first. The multiplicand magnitude is
// pre-shifted so that each digit's partial product lands at the correct weight.
// The sign fixup is applied once, on the final iteration, when the product
// register is loaded.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   in_valid     operand set presented on a, b, signed_mode
//   in_ready     high only in IDLE (pure state decode)
//   a, b         multiplicand / multiplier, WIDTH bits
//   signed_mode  1 = two's-complement operands and result
//   out_valid    product holds a completed result (DONE)
//   out_ready    consumer accepts product
//   product      exact 2*WIDTH-bit a*b, held until next load or reset
//   busy         high in BUSY or DONE
// ---------------------------------------------------------------------------
module iter_mul #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int PW    = 2 * WIDTH;
    localparam int ITER  = WIDTH / DIGIT;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [PW-1:0]      a_sh_r;     // |a| shifted to the weight of the current digit
    logic [WIDTH-1:0]   b_mag_r;    // |b|, shifted right one digit per cycle
    logic [PW-1:0]      acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_r;      // result must be negated
    logic [PW-1:0]      product_r;
    logic               out_valid_r;
    logic               busy_r;

    logic [DIGIT-1:0]   digit_s;
    logic [PW-1:0]      partial_s;
    logic [PW-1:0]      sum_s;
    logic [PW-1:0]      result_s;

    // Magnitude of a WIDTH-bit operand. The most negative value maps onto
    // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                    input logic           is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = ~v + WIDTH'(1'b1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Partial product of the current digit, running sum and sign fixup.
    always_comb begin
        digit_s   = b_mag_r[DIGIT-1:0];
        partial_s = a_sh_r * PW'(digit_s);
        sum_s     = acc_r + partial_s;
        // Two's-complement negation of zero is zero, but gate it anyway so a
        // zero product can never pick up a sign.
        if (neg_r && (sum_s != {PW{1'b0}})) begin
            result_s = ~sum_s + PW'(1'b1);
        end else begin
            result_s = sum_s;
        end
    end

    // Control FSM, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_sh_r      <= {PW{1'b0}};
            b_mag_r     <= {WIDTH{1'b0}};
            acc_r       <= {PW{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            neg_r       <= 1'b0;
            product_r   <= {PW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r  <= PW'(magnitude(a, signed_mode));
                        b_mag_r <= magnitude(b, signed_mode);
                        neg_r   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_r   <= {PW{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    acc_r   <= sum_s;
                    a_sh_r  <= a_sh_r << DIGIT;
                    b_mag_r <= b_mag_r >> DIGIT;
                    cnt_r   <= cnt_r + CNT_W'(1'b1);
                    if (cnt_r == LAST_CNT) begin
                        product_r   <= result_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    // Operands offered in this cycle are not taken; the
                    // handshake only returns the block to IDLE.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = product_r;

endmodule

// File: tb/tb_iter_mul.sv
// ---------------------------------------------------------------------------
// tb_iter_mul : directed checks on a WIDTH=16/DIGIT=2 instance plus random
// handshake traffic on instances with DIGIT = 1, 2, 4, 8 and 16, each checked
// against a plain-arithmetic golden product and the expected latency 16/DIGIT.
// ---------------------------------------------------------------------------
module tb_iter_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Golden product from integer arithmetic.
    function automatic logic [31:0] golden(input logic [15:0] x, input logic [15:0] y,
                                           input logic m);
        longint sx, sy;
        sx = m ? longint'($signed(x)) : longint'(x);
        sy = m ? longint'($signed(y)) : longint'(y);
        return 32'(sx * sy);
    endfunction

    // Operand picker biased toward the arithmetic corner cases.
    function automatic logic [15:0] pick();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h8000;
            1: v = 16'hFFFF;
            2: v = 16'h0000;
            3: v = 16'h0001;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    // ---------------- directed instance -----------------------------------
    logic        d_rst = 1'b1;
    logic        d_iv = 1'b0, d_or = 1'b0, d_m = 1'b0;
    logic [15:0] d_a = 16'h0, d_b = 16'h0;
    logic        d_ir, d_ov, d_busy;
    logic [31:0] d_prod;

    iter_mul #(.WIDTH(16), .DIGIT(2)) dut (
        .clk(clk), .rst(d_rst), .in_valid(d_iv), .in_ready(d_ir),
        .a(d_a), .b(d_b), .signed_mode(d_m), .out_valid(d_ov),
        .out_ready(d_or), .product(d_prod), .busy(d_busy)
    );

    // Present one operand set from IDLE, wait for DONE, check latency/product.
    task automatic d_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                        input logic [31:0] exp, input string tag);
        int lat;
        check_eq({tag, " ready"}, d_ir, 1);
        d_a = ta; d_b = tb_; d_m = tm; d_iv = 1'b1;
        @(posedge clk); #1;
        d_iv = 1'b0; d_a = 16'($urandom); d_b = 16'($urandom); d_m = 1'($urandom);
        lat = 0;
        while (!d_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " lat"}, lat, 8);
        check_eq({tag, " prod"}, d_prod, exp);
        check_eq({tag, " busy"}, d_busy, 1);
    endtask

    // Accept the product and confirm the return to IDLE.
    task automatic d_ack(input string tag);
        d_or = 1'b1;
        @(posedge clk); #1;
        d_or = 1'b0;
        check_eq({tag, " ack ov"}, d_ov, 0);
        check_eq({tag, " ack ir"}, d_ir, 1);
    endtask

    // ---------------- random sweep instances ------------------------------
    logic g_rst = 1'b1;

    for (genvar gi = 0; gi < 5; gi++) begin : blk
        localparam int D = 1 << gi;
        logic        iv = 1'b0, orr = 1'b0, m = 1'b0;
        logic [15:0] xa = 16'h0, xb = 16'h0;
        logic        ir, ov, bz;
        logic [31:0] pr;
        bit          done = 1'b0;

        iter_mul #(.WIDTH(16), .DIGIT(D)) u (
            .clk(clk), .rst(g_rst), .in_valid(iv), .in_ready(ir),
            .a(xa), .b(xb), .signed_mode(m), .out_valid(ov),
            .out_ready(orr), .product(pr), .busy(bz)
        );

        initial begin
            int lat;
            int gap;
            logic [31:0] exp;
            wait (g_rst == 1'b0);
            @(posedge clk); #1;
            for (int n = 0; n < 400; n++) begin
                gap = $urandom_range(0, 3);
                for (int k = 0; k < gap; k++) begin
                    @(posedge clk); #1;
                end
                xa = pick(); xb = pick(); m = 1'($urandom);
                exp = golden(xa, xb, m);
                iv = 1'b1;
                check_eq($sformatf("d%0d ready", D), ir, 1);
                @(posedge clk); #1;
                iv = 1'b0; xa = 16'($urandom); xb = 16'($urandom); m = 1'($urandom);
                lat = 0;
                while (!ov && lat < 40) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check_eq($sformatf("d%0d lat", D), lat, 16 / D);
                check_eq($sformatf("d%0d prod", D), pr, exp);
                gap = $urandom_range(0, 3);
                for (int k = 0; k < gap; k++) begin
                    @(posedge clk); #1;
                end
                check_eq($sformatf("d%0d hold", D), {ov, pr}, {1'b1, exp});
                orr = 1'b1;
                @(posedge clk); #1;
                orr = 1'b0;
                check_eq($sformatf("d%0d ack", D), ov, 0);
            end
            done = 1'b1;
        end
    end

    // ---------------- main sequence ---------------------------------------
    initial begin
        int t;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst ir", d_ir, 1);
        check_eq("rst ov", d_ov, 0);
        check_eq("rst busy", d_busy, 0);
        check_eq("rst prod", d_prod, 0);
        d_rst = 1'b0;
        g_rst = 1'b0;
        @(posedge clk); #1;

        d_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "uffff"); d_ack("uffff");
        d_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s8000"); d_ack("s8000");
        d_op(16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF, "sm1");   d_ack("sm1");
        d_op(16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, "um1");   d_ack("um1");
        d_op(16'h0000, 16'h8000, 1'b1, 32'h00000000, "szero"); d_ack("szero");
        d_op(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, "smix");  d_ack("smix");

        // Backpressure: result must be held untouched.
        d_op(16'd3, 16'd5, 1'b0, 32'd15, "bp");
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check_eq("bp hold", {d_ov, d_ir, d_prod}, {1'b1, 1'b0, 32'd15});
        end
        // New operands offered in the same cycle as the acknowledge.
        d_a = 16'd2; d_b = 16'd2; d_m = 1'b0; d_iv = 1'b1; d_or = 1'b1;
        @(posedge clk); #1;
        d_or = 1'b0;
        check_eq("bp idle", {d_ov, d_ir, d_busy}, {1'b0, 1'b1, 1'b0});
        check_eq("bp keep", d_prod, 32'd15);
        @(posedge clk); #1;
        d_iv = 1'b0;
        check_eq("bp accept", {d_busy, d_ir}, {1'b1, 1'b0});
        t = 0;
        while (!d_ov && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("bp second lat", t, 8);
        check_eq("bp second prod", d_prod, 32'd4);
        d_ack("bp2");

        // Reset in the 4th BUSY cycle discards the operation.
        d_a = 16'h1234; d_b = 16'h5678; d_m = 1'b0; d_iv = 1'b1;
        @(posedge clk); #1;
        d_iv = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        d_rst = 1'b1;
        @(posedge clk); #1;
        d_rst = 1'b0;
        check_eq("mid rst", {d_ir, d_ov, d_busy, d_prod}, {1'b1, 1'b0, 1'b0, 32'd0});
        repeat (10) begin
            @(posedge clk); #1;
        end
        check_eq("mid rst quiet", {d_ov, d_prod}, {1'b0, 32'd0});
        d_op(16'd7, 16'd9, 1'b0, 32'd63, "post rst"); d_ack("post rst");

        t = 0;
        while (!(blk[0].done && blk[1].done && blk[2].done && blk[3].done && blk[4].done)
               && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check_eq("sweep done",
                 {blk[4].done, blk[3].done, blk[2].done, blk[1].done, blk[0].done}, 5'b11111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
